sram_2048x64_ctrl: RTL
======================

SRAM_2048X64_CTRL -- requirements
Module: sram_2048x64_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 11, SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, SRAM word width.
REQ-003 SHALL have parameter MEM_DEPTH, default 2048, number of SRAM words.
REQ-004 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_BITS  word address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port rsp_valid  output  1  read data available.
REQ-012 SHALL have port rsp_ready  input  1  consumer takes read data.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH  read data, oldest first.
REQ-014 SHALL have port init_done  output  1  controller open for requests.
REQ-015 SHALL have ports sram_me, sram_we (output 1), sram_adr (output ADDR_BITS), sram_d (output DATA_WIDTH), sram_q (input DATA_WIDTH), connected to SRAM ME, WE, ADR, D, Q.

Function
REQ-016 SHALL accept a request on a rising edge where req_valid && req_ready.
REQ-017 SHALL drive sram_me = req_valid && req_ready, sram_we = req_we, sram_adr = req_addr, sram_d = req_wdata combinationally in RUN state.
REQ-018 SHALL set a rd_pending flag on an accepted read and capture sram_q into the response buffer on the following edge; rsp_valid rises 2 cycles after acceptance.
REQ-019 SHALL hold a 2-entry in-order response buffer; rsp_rdata/rsp_valid reflect the head entry; the head pops on rsp_valid && rsp_ready.
REQ-020 SHALL drive req_ready = init_done && (occupancy + rd_pending < 2), identical for reads and writes; req_ready never depends on req_valid.
REQ-021 SHALL, on a simultaneous pop and capture, pop the head first; occupancy stays unchanged; no entry is ever lost or overwritten.
REQ-022 SHALL keep rsp_rdata stable while rsp_valid && !rsp_ready.
REQ-023 SHALL leave write-then-read to the same address to return the new data (SRAM-ordered, no bypass needed).
REQ-024 SHALL be a state machine with states INIT and RUN; RUN is terminal until reset.

Reset
REQ-025 SHALL, while RST_N low: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, sram_me=0, sram_we=0, sram_adr=0, sram_d=0, buffer empty, rd_pending=0.
REQ-026 SHALL, on reset assertion mid-operation, discard pending reads and buffered data and restart from the post-reset state.

Configuration
REQ-027 SHALL, with SRAM_CTRL_INIT_EN defined, enter INIT after reset, write 0 to addresses 0..MEM_DEPTH-1, one per cycle (sram_me=1, sram_we=1, sram_d=0), and enter RUN with init_done=1 on the edge after the write to MEM_DEPTH-1.
REQ-028 SHALL, without SRAM_CTRL_INIT_EN, enter RUN directly; init_done=1 on the first edge after reset release.

Structure
REQ-029 SHALL take ADDR_BITS/DATA_WIDTH/MEM_DEPTH defaults and the state enum (INIT, RUN) from package sram_ctrl_pkg.
REQ-030 SHALL implement the response buffer as sub-module sram_rsp_buf (2-entry FIFO, push/pop/count).

Verification
REQ-031 SHALL cover: write 0x0123_4567_89AB_CDEF to addr 5, read addr 5 -> rsp_rdata 0x0123456789ABCDEF, rsp_valid 2 cycles after accept.
REQ-032 SHALL cover: rsp_ready=0, three back-to-back reads -> first two accepted, req_ready=0 for the third until a pop.
REQ-033 SHALL cover: reads to addrs 0, 1, 2 with rsp_ready toggling 1,0,1 -> responses in order, no loss, stable data while stalled.
REQ-034 SHALL cover (SRAM_CTRL_INIT_EN): release reset -> init_done rises after 2048 cycles; read addr 2047 -> 0.
REQ-035 SHALL cover: RST_N pulsed low with one read pending and one buffered -> rsp_valid=0 immediately, no stale response after release.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the 2048x64 SRAM controller.
// Provides default geometry for the controller parameters and the
// controller state encoding.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_BITS  = 11;
  localparam int unsigned SRAM_DATA_WIDTH = 64;
  localparam int unsigned SRAM_MEM_DEPTH  = 2048;

  // Response buffer depth (the buffer RTL is written for exactly two entries)
  localparam int unsigned RSP_BUF_DEPTH = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/sram_rsp_buf.sv
// Two-entry in-order read-response FIFO.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset (clears all entries to 0)
//   i_push           store i_push_data at the tail
//   i_push_data      data to store
//   i_pop            drop the head entry
//   o_head_data      head entry (stale contents when empty)
//   o_count          number of valid entries (0..2)
module sram_rsp_buf
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_mem [RSP_BUF_DEPTH];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;
  logic                  w_do_pop;
  logic                  w_do_push;

  // Pop is evaluated first so a push into a full buffer is legal only when
  // the head leaves in the same cycle; the tail then reuses the freed slot.
  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(RSP_BUF_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
    end
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_count     = r_count;

endmodule

// File: rtl/sram_2048x64_ctrl.sv
// Request/response controller in front of a single-port 2048x64 SRAM with
// one-cycle read latency (Q valid after the edge that samples ME/ADR).
// Optional feature: define SRAM_CTRL_INIT_EN to zero-fill the whole SRAM
// after reset before the controller opens for requests.
// Ports:
//   CLK, RST_N                 clock, async active-low reset
//   req_valid/req_ready        request handshake (accept on valid && ready)
//   req_we, req_addr, req_wdata  request payload (we=1 write, 0 read)
//   rsp_valid/rsp_ready        read-response handshake
//   rsp_rdata                  read data, oldest first
//   init_done                  controller open for requests
//   sram_me/we/adr/d, sram_q   SRAM macro interface
module sram_2048x64_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = SRAM_ADDR_BITS,
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH  = SRAM_MEM_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_BITS-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  sram_me,
  output logic                  sram_we,
  output logic [ADDR_BITS-1:0]  sram_adr,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  // Catch a depth that the address bus cannot reach
  if (64'(MEM_DEPTH) > (64'd1 << ADDR_BITS)) begin : g_depth_chk
    $error("sram_2048x64_ctrl: MEM_DEPTH exceeds 2**ADDR_BITS");
  end

  ctrl_state_e r_state;
  logic        r_init_done;
  logic        r_rd_pending;
  logic [1:0]  w_count;
  logic [2:0]  w_occ;
  logic        w_req_ready;
  logic        w_accept;
  logic        w_rd_accept;
  logic        w_pop;

`ifdef SRAM_CTRL_INIT_EN
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MEM_DEPTH - 1);
  logic [ADDR_BITS-1:0] r_init_addr;
`endif

  // A read in flight already owns a buffer slot, so it counts as occupancy
  assign w_occ       = 3'(w_count) + 3'(r_rd_pending);
  assign w_req_ready = r_init_done && (w_occ < 3'd2);
  assign w_accept    = req_valid && w_req_ready;
  assign w_rd_accept = w_accept && !req_we;
  assign w_pop       = rsp_valid && rsp_ready;

  assign req_ready = w_req_ready;
  assign init_done = r_init_done;
  assign rsp_valid = (w_count != 2'd0);

  // Controller state, init sweep and read-in-flight tracking
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= INIT;
      r_init_done  <= 1'b0;
      r_rd_pending <= 1'b0;
`ifdef SRAM_CTRL_INIT_EN
      r_init_addr  <= '0;
`endif
    end else begin
      r_rd_pending <= w_rd_accept;
      case (r_state)
        INIT: begin
`ifdef SRAM_CTRL_INIT_EN
          if (r_init_addr == LAST_ADDR) begin
            r_state     <= RUN;
            r_init_done <= 1'b1;
          end else begin
            r_init_addr <= r_init_addr + ADDR_BITS'(1);
          end
`else
          r_state     <= RUN;
          r_init_done <= 1'b1;
`endif
        end
        RUN:     r_state <= RUN;
        default: r_state <= INIT;
      endcase
    end
  end

  // SRAM port: pass-through in RUN, zero-fill sweep in INIT
  always_comb begin
    sram_me  = 1'b0;
    sram_we  = 1'b0;
    sram_adr = '0;
    sram_d   = '0;
    if (r_state == RUN) begin
      sram_me  = w_accept;
      sram_we  = req_we;
      sram_adr = req_addr;
      sram_d   = req_wdata;
    end
`ifdef SRAM_CTRL_INIT_EN
    // RST_N gating keeps the macro idle while reset is held in INIT
    else if (RST_N) begin
      sram_me  = 1'b1;
      sram_we  = 1'b1;
      sram_adr = r_init_addr;
    end
`endif
  end

  // Read data is captured one edge after the SRAM sampled the read
  sram_rsp_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_buf (
    .i_clk       (CLK),
    .i_rst_n     (RST_N),
    .i_push      (r_rd_pending),
    .i_push_data (sram_q),
    .i_pop       (w_pop),
    .o_head_data (rsp_rdata),
    .o_count     (w_count)
  );

endmodule
